ram32k_arbiter: RTL and testbench
=================================

RAM32K_ARBITER -- requirements
Module: ram32k_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, memory address width (DEPTH = 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have parameter INIT_ON_RESET, default 1, zero-fill the memory after reset when 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports a_req / b_req  input  1  requester A/B access request.
REQ-007 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr / b_addr  input  ADDR_W  word address.
REQ-009 SHALL have ports a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports a_gnt / b_gnt  output  1  request accepted this cycle (combinational).
REQ-011 SHALL have ports a_rvalid / b_rvalid  output  1  read data valid.
REQ-012 SHALL have ports a_rdata / b_rdata  output  DATA_W  read data.
REQ-013 SHALL have ports mem_en, mem_we  output  1  memory enable / write enable.
REQ-014 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  memory address / write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en && !mem_we.
REQ-016 SHALL have port init_busy  output  1  zero-fill in progress.

Function
REQ-017 SHALL implement FSM states INIT and RUN; after reset enter INIT if INIT_ON_RESET=1, else RUN.
REQ-018 In INIT SHALL drive mem_en=1, mem_we=1, mem_wdata=0, mem_addr=init counter, counter 0 to DEPTH-1, one word per cycle.
REQ-019 SHALL transition INIT->RUN on the cycle after writing address DEPTH-1 (DEPTH cycles of init_busy=1); counter SHALL not wrap.
REQ-020 In INIT a_gnt=b_gnt=0 regardless of requests; requests SHALL be held by requesters (no queuing).
REQ-021 In RUN SHALL grant exactly one requester per cycle at most; a single requesting port SHALL be granted immediately.
REQ-022 On simultaneous a_req and b_req SHALL grant the port not granted most recently (round-robin pointer; A wins first contention after reset).
REQ-023 Round-robin pointer SHALL update only on a grant.
REQ-024 On grant SHALL drive mem_en=1, mem_we/mem_addr/mem_wdata from the granted port in the same cycle; no grant -> mem_en=0, mem_we=0.
REQ-025 For a granted read SHALL assert the granted port's rvalid exactly one cycle later with rdata = mem_rdata of that cycle.
REQ-026 Granted writes SHALL produce no rvalid; read-after-write to the same address in consecutive grants SHALL return the new data.
REQ-027 x_rdata SHALL hold its last value when x_rvalid=0.
REQ-028 Back-to-back grants SHALL sustain one access per cycle (full throughput, reads pipelined).

Reset
REQ-029 On rst_n low, all outputs SHALL go to 0 asynchronously: gnt, rvalid, rdata, mem_* = 0; init_busy = INIT_ON_RESET.
REQ-030 Reset asserted mid-INIT SHALL restart zero-fill at address 0; mid-RUN SHALL discard any pending rvalid.
REQ-031 Round-robin pointer and init counter SHALL reset to 0 (pointer favours A).

Structure
REQ-032 Shared package ram32k_pkg SHALL hold ADDR_W/DATA_W defaults, DEPTH, and the FSM state enum {INIT, RUN}.
REQ-033 Round-robin decision SHALL be a sub-module rr_arb2 (2-input request, last-grant pointer, one-hot grant).
REQ-034 Memory array SHALL be external to this block.

Verification
REQ-035 Reset with INIT_ON_RESET=1 -> init_busy high exactly 32768 cycles, mem writes 0 to addresses 0..32767 in order, then A read of 0x1234 -> a_rdata 0.
REQ-036 A writes 0xDEADBEEF to 0x0010, next cycle A reads 0x0010 -> a_rvalid one cycle after grant, a_rdata 0xDEADBEEF.
REQ-037 a_req and b_req held for 4 cycles -> grants A,B,A,B; each read returns correct per-port rvalid/rdata one cycle later.
REQ-038 Requests during INIT -> no gnt until first RUN cycle, then granted per REQ-022.
REQ-039 rst_n pulsed low at init address 0x4000 -> outputs zero immediately, zero-fill restarts at 0x0000.
REQ-040 B reads 0x7FFF, rst_n low same cycle rvalid due -> b_rvalid stays 0.

Source files
------------

// File: rtl/ram32k_pkg.sv
// rtl/ram32k_pkg.sv - shared defaults and FSM state type for the 32K-word memory arbiter
package ram32k_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with one-hot grant (bit 0 = A, bit 1 = B)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Set when B is owed the next contested grant; clear after reset so A wins first.
    logic       r_prio_b;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_prio_b ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio_b <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio_b <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/ram32k_arbiter.sv
// rtl/ram32k_arbiter.sv - zero-fill then round-robin share of one external single-port memory
module ram32k_arbiter
    import ram32k_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] w_init_cnt_nxt;
    logic              w_run;
    logic [1:0]        w_gnt;
    logic              r_a_pend;
    logic              r_b_pend;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT_ON_RESET ? INIT : RUN;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // The counter parks on the last address rather than wrapping as INIT ends.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            INIT: begin
                if (&r_init_cnt) begin
                    w_state_nxt = RUN;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_run = rst_n && (r_state == RUN);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_run),
        .i_req ({b_req, a_req}),
        .o_gnt (w_gnt)
    );

    assign a_gnt     = w_gnt[0];
    assign b_gnt     = w_gnt[1];
    assign init_busy = (r_state == INIT);

    // Memory strobes are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (r_state == INIT) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_init_cnt;
            end else if (w_gnt[0]) begin
                mem_en    = 1'b1;
                mem_we    = a_we;
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
            end else if (w_gnt[1]) begin
                mem_en    = 1'b1;
                mem_we    = b_we;
                mem_addr  = b_addr;
                mem_wdata = b_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_pend  <= 1'b0;
            r_b_pend  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_pend <= w_gnt[0] && !a_we;
            r_b_pend <= w_gnt[1] && !b_we;
            if (r_a_pend) begin
                r_a_rdata <= mem_rdata;
            end
            if (r_b_pend) begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

    // Read data flows straight from memory in the valid cycle, then is held.
    assign a_rvalid = r_a_pend;
    assign b_rvalid = r_b_pend;
    assign a_rdata  = r_a_pend ? mem_rdata : r_a_rdata;
    assign b_rdata  = r_b_pend ? mem_rdata : r_b_rdata;

endmodule

// File: tb/tb_ram32k_arbiter.sv
// tb/tb_ram32k_arbiter.sv - self-checking bench for ram32k_arbiter with external memory model
module tb_ram32k_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          init_busy;

    ram32k_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    // External single-port memory with one-cycle read latency.
    logic [DW-1:0] phys_mem [NW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= phys_mem[mem_addr];
        end
    end

    // Reference model: expected memory contents, last winner, per-port read results.
    logic [DW-1:0] ref_mem [NW];
    int            last_gnt;
    logic          exp_a_rv, exp_b_rv;
    logic [DW-1:0] exp_a_rd, exp_b_rd;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic model_reset();
        last_gnt = 0;
        exp_a_rv = 1'b0; exp_b_rv = 1'b0;
        exp_a_rd = '0;   exp_b_rd = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, mem_en, mem_we, mem_addr, mem_wdata}, '0);
        chk({tag, "_busy"}, init_busy, 1'b1);
    endtask

    task automatic chk_init(input logic [AW-1:0] addr);
        chk("init_cycle", {mem_en, mem_we, mem_addr, mem_wdata, a_gnt, b_gnt, init_busy},
            {1'b1, 1'b1, addr, 32'h0, 1'b0, 1'b0, 1'b1});
    endtask

    // Releases reset on a falling edge and follows the zero-fill for n cycles.
    task automatic release_and_init(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_init('0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            #1;
            chk_init(AW'(i));
        end
    endtask

    task automatic run_cycle(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        logic ga, gb;
        @(negedge clk);
        drive(ar, aw, aa, ad, br, bw, ba, bd);
        #1;
        chk("a_rvalid", a_rvalid, exp_a_rv);
        chk("a_rdata", a_rdata, exp_a_rd);
        chk("b_rvalid", b_rvalid, exp_b_rv);
        chk("b_rdata", b_rdata, exp_b_rd);
        chk("run_busy", init_busy, 1'b0);
        if (ar && br) ga = (last_gnt != 1);
        else          ga = ar;
        gb = br && !ga;
        chk("gnt", {a_gnt, b_gnt}, {ga, gb});
        chk("mem_en_we", {mem_en, mem_we}, {ga | gb, (ga & aw) | (gb & bw)});
        if (ga) chk("mem_a_fields", {mem_addr, mem_wdata}, {aa, ad});
        if (gb) chk("mem_b_fields", {mem_addr, mem_wdata}, {ba, bd});
        exp_a_rv = ga && !aw;
        exp_b_rv = gb && !bw;
        if (exp_a_rv) exp_a_rd = ref_mem[aa];
        if (exp_b_rv) exp_b_rd = ref_mem[ba];
        if (ga && aw) ref_mem[aa] = ad;
        if (gb && bw) ref_mem[ba] = bd;
        if (ga) last_gnt = 1;
        if (gb) last_gnt = 2;
    endtask

    task automatic idle_cycle();
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < NW; i++) phys_mem[i] = $urandom;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset_outputs");

        // Full zero-fill, then a read of a location that held garbage.
        release_and_init(NW);
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        run_cycle(1'b1, 1'b0, 15'h1234, '0, 1'b0, 1'b0, '0, '0);
        chk("a_gnt_1234", a_gnt, 1'b1);
        idle_cycle();
        chk("read_1234_zero", {a_rvalid, a_rdata}, {1'b1, 32'h0});

        // Write then immediately read back the same address.
        run_cycle(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        run_cycle(1'b1, 1'b0, 15'h0010, '0, 1'b0, 1'b0, '0, '0);
        chk("raw_no_rvalid_yet", a_rvalid, 1'b0);
        idle_cycle();
        chk("raw_rdata", {a_rvalid, a_rdata}, {1'b1, 32'hDEADBEEF});

        // B wins last so that the following contention alternates starting with A.
        run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 15'h0020, 32'hB0B00020);
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b1, 1'b0, 15'h0010, '0, 1'b1, 1'b0, 15'h0020, '0);
            chk("rr_alternate", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle_cycle();
        chk("rr_last_b_rdata", {b_rvalid, b_rdata}, {1'b1, 32'hB0B00020});

        random_cycles(300);
        idle_cycle();

        // Reset lands in the cycle a B read would have returned.
        run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h7FFF, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("b_rvalid_discarded", b_rvalid, 1'b0);
        chk_reset_outputs("reset_mid_run");
        model_reset();

        // Interrupt the zero-fill at 0x4000, then hold both requests through a full fill.
        release_and_init(16'h4001);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_init");
        drive(1'b1, 1'b0, 15'h0001, '0, 1'b1, 1'b0, 15'h0002, '0);
        release_and_init(NW);
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        model_reset();
        run_cycle(1'b1, 1'b0, 15'h0001, '0, 1'b1, 1'b0, 15'h0002, '0);
        chk("first_run_gnt", {a_gnt, b_gnt}, 2'b10);
        random_cycles(200);
        idle_cycle();
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
